// File: rtl/pwm_bank_if.sv
// Control/status bundle for pwm_bank: the master drives configuration and duty
// writes, the slave (the PWM bank) returns outputs and buffering status.
interface pwm_bank_if #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                  enable;
    logic [PRESCALE_W-1:0] prescale;
    logic                  wr_en;
    logic [CH_W-1:0]       wr_ch;
    logic [WIDTH-1:0]      wr_duty;
    logic [CHANNELS-1:0]   pwm_out;
    logic [CHANNELS-1:0]   pending;
    logic                  period_tick;

    modport master (
        output enable, prescale, wr_en, wr_ch, wr_duty,
        input  pwm_out, pending, period_tick
    );

    modport slave (
        input  enable, prescale, wr_en, wr_ch, wr_duty,
        output pwm_out, pending, period_tick
    );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: shared prescaler and period counter, per-channel
// double-buffered duty registers that switch over only at the period wrap.
module pwm_bank #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_bank_if.slave    bus
);
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [WIDTH-1:0]      cnt;
    logic [WIDTH-1:0]      shadow [CHANNELS];
    logic [WIDTH-1:0]      active [CHANNELS];
    logic [CHANNELS-1:0]   pending_q;
    logic [CHANNELS-1:0]   pwm_q;
    logic                  period_tick_q;
    logic                  tick;
    logic                  boundary;

    // >= rather than == so a prescale lowered below pre_cnt ticks at once instead of wrapping.
    assign tick     = bus.enable && (pre_cnt >= bus.prescale);
    assign boundary = tick && (cnt == {WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (!bus.enable) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= cnt + WIDTH'(1);
        end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_tick_q <= 1'b0;
        end else begin
            period_tick_q <= boundary;
        end
    end

    // The boundary transfer is written first so a same-cycle write lands in the shadow after the old value moves over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                shadow[c] <= '0;
                active[c] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (boundary && pending_q[c]) begin
                    active[c]    <= shadow[c];
                    pending_q[c] <= 1'b0;
                end
                if (bus.wr_en && (bus.wr_ch == CH_W'(c))) begin
                    shadow[c] <= bus.wr_duty;
                    if (bus.enable) begin
                        pending_q[c] <= 1'b1;
                    end else begin
                        active[c]    <= bus.wr_duty;
                        pending_q[c] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                pwm_q[c] <= bus.enable && (cnt < active[c]);
            end
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.pending     = pending_q;
    assign bus.period_tick = period_tick_q;
endmodule
